// File: rtl/piezo_sequencer_if.sv
// Memory-mapped CPU bus for the piezo note sequencer.
// Single-cycle Write/Read strobes, registered Ack with DataOut.
interface piezo_sequencer_if;
    logic        Addr;
    logic [31:0] DataIn;
    logic        Write;
    logic        Read;
    logic [31:0] DataOut;
    logic        Ack;

    modport master (
        output Addr, DataIn, Write, Read,
        input  DataOut, Ack
    );

    modport slave (
        input  Addr, DataIn, Write, Read,
        output DataOut, Ack
    );
endinterface

// File: rtl/piezo_sequencer.sv
// Note-queue sequencer feeding the piezo driver write/ack port.
// Optional replay mode is built when PIEZO_SEQ_LOOP_EN is defined.
module piezo_sequencer #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 100000
) (
    input  logic             clock,
    input  logic             reset,
    piezo_sequencer_if.slave bus,
    output logic [24:0]      Piezo_Data,
    output logic             Piezo_Write,
    input  logic             Piezo_Ack
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WAIT,
        S_PLAY, S_STOP, S_SACK
    } state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          rd_clr;
    logic          armed;
    logic          flush_pend;
    logic          loop_q;
    logic [23:0]   cur_hp;
    logic [7:0]    cur_dur;
    logic [TW-1:0] tick;

    logic          full;
    logic          empty;
    logic          busy;
    logic          note_wr;
    logic          ctl_wr;
    logic          flush;
    logic          push;
    logic          pop;
    logic          repush;
    logic          tick_wrap;
    logic [31:0]   head;
    logic [31:0]   status;
    logic [7:0]    count8;

    // Bus decode, FIFO flags and the pop decision for this cycle
    always_comb begin
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        busy      = (state != S_IDLE);
        note_wr   = bus.Write && !bus.Addr;
        ctl_wr    = bus.Write && bus.Addr;
        flush     = ctl_wr && bus.DataIn[0];
        push      = note_wr && !full;
        head      = mem[rptr];
        tick_wrap = (tick == TICK_MAX);
        count8    = 8'(count);
        pop = !flush && !empty &&
              ((state == S_IDLE) ||
               (state == S_CHECK && cur_dur == 8'd0) ||
               (state == S_PLAY && tick_wrap &&
                cur_dur == 8'd1));
        repush = pop && loop_q;
`ifdef PIEZO_SEQ_LOOP_EN
        status = {15'b0, count8, 4'b0, loop_q,
                  overflow, busy, full, empty};
`else
        status = {16'b0, count8, 4'b0,
                  overflow, busy, full, empty};
`endif
    end

`ifdef PIEZO_SEQ_LOOP_EN
    // Replay mode: set by control bit 1, dropped by flush
    always_ff @(posedge clock) begin
        if (reset) begin
            loop_q <= 1'b0;
        end else if (flush) begin
            loop_q <= 1'b0;
        end else if (ctl_wr && bus.DataIn[1]) begin
            loop_q <= 1'b1;
        end
    end
`else
    assign loop_q = 1'b0;
`endif

    // Note storage: replayed head lands first, bus note after it
    always_ff @(posedge clock) begin
        if (!reset && !flush) begin
            if (repush) begin
                mem[wptr] <= head;
            end
            if (push) begin
                mem[wptr + PW'(repush)] <= bus.DataIn;
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(repush) + PW'(push);
            rptr  <= rptr + PW'(pop);
            count <= count + CW'(repush) + CW'(push)
                     - CW'(pop);
        end
    end

    // Bus acknowledge, read data and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.Ack     <= 1'b0;
            bus.DataOut <= '0;
            rd_clr      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            bus.Ack <= bus.Write | bus.Read;
            if (bus.Read) begin
                bus.DataOut <= bus.Addr ? status : '0;
            end
            rd_clr <= bus.Read && bus.Addr;
            if (note_wr && full) begin
                overflow <= 1'b1;
            end else if ((ctl_wr && bus.DataIn[2]) || rd_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Playback sequencer driving the piezo write/ack port
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            Piezo_Data  <= '0;
            Piezo_Write <= 1'b0;
            cur_hp      <= '0;
            cur_dur     <= '0;
            tick        <= '0;
            armed       <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            Piezo_Write <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (flush) begin
                        state <= S_STOP;
                    end else if (pop) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (flush) begin
                        state <= S_STOP;
                    end else if (cur_dur == 8'd0) begin
                        if (pop) begin
                            state <= S_CHECK;
                        end else if (armed) begin
                            state <= S_STOP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        Piezo_Data  <= {|cur_hp, cur_hp};
                        Piezo_Write <= 1'b1;
                        armed       <= 1'b1;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (Piezo_Ack) begin
                        tick       <= '0;
                        flush_pend <= 1'b0;
                        state <= (flush || flush_pend) ?
                                 S_STOP : S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (flush) begin
                        state <= S_STOP;
                    end else begin
                        tick <= tick_wrap ? '0 : tick + TW'(1);
                        if (tick_wrap) begin
                            cur_dur <= cur_dur - 8'd1;
                            if (cur_dur == 8'd1) begin
                                state <= pop ? S_CHECK : S_STOP;
                            end
                        end
                    end
                end
                S_STOP: begin
                    Piezo_Data  <= '0;
                    Piezo_Write <= 1'b1;
                    armed       <= 1'b0;
                    state       <= S_SACK;
                end
                S_SACK: begin
                    if (Piezo_Ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (pop) begin
                cur_hp  <= head[23:0];
                cur_dur <= head[31:24];
            end
        end
    end
endmodule

// File: doc/piezo_sequencer.md
Name: piezo_sequencer

Overview:
- Note-queue sequencer that sits directly upstream of the piezo driver and drives its 25-bit data/Write/Ack interface.
- The CPU pushes notes over the memory-mapped bus. Each note is a half-period compare value plus a duration.
- The block plays the queued notes back-to-back with exact durations, then silences the driver. The CPU does not have to time each note in software.

Parameters:
- DEPTH, 8, note FIFO entries (power of two, 2..64)
- TICK_DIV, 100000, clock cycles per duration tick (1 ms at 100 MHz); at least 2

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Addr  in  1  0 = note FIFO, 1 = control/status
- DataIn  in  32  write data
- Write  in  1  single-cycle write strobe
- Read  in  1  single-cycle read strobe
- DataOut  out  32  read data, valid with Ack
- Ack  out  1  bus acknowledge
- Piezo_Data  out  25  to driver: {enable, half-period[23:0]}
- Piezo_Write  out  1  to driver: write strobe
- Piezo_Ack  in  1  from driver: write acknowledge

Behaviour:
- Reset and timing rules:
  - Reset values: Ack=0, DataOut=0, Piezo_Data=0, Piezo_Write=0. FIFO empty, overflow=0, state IDLE, tick and duration counters 0.
  - All outputs are registered.
  - A reset asserted mid-note aborts immediately with no stop write; the driver shares the same reset.
- Bus handshake:
  - Ack is asserted the cycle after Write or Read; Ack = reset ? 0 : (Write|Read).
  - DataOut is valid in the Ack cycle and holds otherwise.
- Note write (Addr=0): DataIn[23:0] is the half-period, DataIn[31:24] is the duration in ticks.
  - Not full: the note is pushed.
  - Full: the note is dropped, overflow is set (sticky), and Ack is still returned.
  - A push is judged on the full flag in that cycle, even if a pop happens in the same cycle.
- Control write (Addr=1):
  - DataIn[0]=1 flushes: FIFO emptied, the playing note is aborted, FSM goes to STOP.
  - DataIn[2]=1 clears overflow.
- Status read (Addr=1): DataOut = {16'b0, count[7:0], 4'b0, overflow, busy, full, empty}. busy = (state != IDLE).
  - Reading status clears overflow one cycle after Ack; an overflow set in that same cycle wins.
  - A read with Addr=0 returns 0.
- FSM:
  - IDLE: if the FIFO is not empty, pop the note into cur_hp/cur_dur and go to CHECK.
  - CHECK:
    - cur_dur == 0: note skipped. Next is CHECK via pop if the FIFO is not empty, otherwise STOP if a tone was previously enabled, otherwise IDLE.
    - Else: Piezo_Data = {cur_hp != 0, cur_hp}. A half-period of 0 is a rest (driver disabled). Pulse Piezo_Write for exactly 1 cycle, then go to WAIT.
  - WAIT: hold until Piezo_Ack=1, then go to PLAY; the tick counter is cleared that cycle.
  - PLAY: the tick counter counts 0..TICK_DIV-1.
    - At wrap, decrement cur_dur.
    - When cur_dur reaches 0 at a wrap:
      - FIFO not empty: pop the next note and go to CHECK (gap of 3 cycles + driver ack latency).
      - FIFO empty: go to STOP.
  - STOP: Piezo_Data = 25'h0, pulse Piezo_Write for 1 cycle, wait for Piezo_Ack, then go to IDLE.
- Note duration is cur_dur*TICK_DIV cycles, measured from the Piezo_Ack cycle to the exit from PLAY.
- Flush during WAIT or STOP: the FIFO is cleared. The outstanding driver ack is still awaited before the STOP write is issued.
- Count width is clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.

Optional Feature:
- Macro PIEZO_SEQ_LOOP_EN.
- Defined: control bit DataIn[1] sets loop mode, readable at status bit 4 (the remaining status bits shift up by one).
  - In loop mode, every popped note is re-pushed at the tail in the same cycle, so the queue replays endlessly. The re-push is exempt from the full check.
  - Flush clears loop mode.
- Undefined: DataIn[1] is ignored and status bit 4 reads 0 (no layout shift). The queue plays once.

Test Plan:
- Reset, then read status (Addr=1) -> DataOut=32'h00000001, Ack one cycle after Read, Piezo_Write never pulsed.
- TICK_DIV=4. Push 0x03_001234 -> Piezo_Data=0x1001234 pulsed once. After Piezo_Ack, 12 cycles in PLAY, then Piezo_Data=0 pulsed. busy returns to 0.
- TICK_DIV=4. Push 0x02_000010, 0x00_000020, 0x01_000000 -> writes 0x1000010, 0x0000000 (rest; the duration-0 note is skipped), then 0x0000000 stop. Durations 8 and 4 cycles.
- DEPTH=8, no playback ack (Piezo_Ack tied 0 after the first pop). Push 10 notes -> count saturates at 8, overflow=1. Status read clears overflow.
- Mid-PLAY control write 0x1 -> FIFO empty, STOP write 25'h0 issued, IDLE. A subsequent push plays normally.
- With PIEZO_SEQ_LOOP_EN: push 2 notes, set loop -> write sequence A,B,A,B,… with count stable at 2. Flush -> stop write, loop bit reads 0.
